instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter IMEM_BASE, default 32'h8000_0000, meaning the lowest legal fetch address.
REQ-003 The block SHALL have parameter IMEM_LIMIT, default 32'h8000_FFFF, meaning the highest legal byte address.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset).
REQ-005 The block SHALL have imem_addr (output, 32, byte address to the combinational instruction memory) and imem_rdata (input, 32, instruction word valid in the same cycle).
REQ-006 The block SHALL have redirect_valid (input, 1) and redirect_pc (input, 32), meaning a branch/jump target from execute.
REQ-007 The block SHALL have out_valid (output, 1), out_ready (input, 1), out_pc (output, 32), out_instr (output, 32) and out_pc_plus4 (output, 32), forming the decode-side valid/ready port.
REQ-008 The block SHALL have fault_valid (output, 1), fault_cause (output, 2: 00 none, 01 misaligned, 10 out-of-range) and fault_addr (output, 32).

Function
REQ-009 imem_addr SHALL equal pc_q combinationally in every state.
REQ-010 States SHALL be FETCH and FAULT.
REQ-011 In FETCH, when (!out_valid || out_ready) and no redirect, the block SHALL on the clock edge load out_pc<=pc_q, out_instr<=imem_rdata, out_pc_plus4<=pc_q+4, out_valid<=1, pc_q<=pc_q+4, for one-cycle fetch latency and one instruction per cycle throughput.
REQ-012 When out_valid && !out_ready, the output register and pc_q SHALL hold unchanged.
REQ-013 When out_valid && out_ready and no new fetch is possible (FAULT state), out_valid SHALL clear on the next edge.
REQ-014 redirect_valid SHALL take priority over all other events: on the edge, out_valid<=0 (flush), pc_q<=redirect_pc; an instruction accepted in that same cycle (out_valid && out_ready) counts as consumed.
REQ-015 A redirect target with redirect_pc[1:0]!=0 SHALL move to FAULT with fault_cause=01 and fault_addr=redirect_pc.
REQ-016 A redirect target outside [IMEM_BASE, IMEM_LIMIT] SHALL move to FAULT with fault_cause=10 and fault_addr=redirect_pc; misaligned SHALL take precedence over out-of-range when both apply.
REQ-017 A sequential increment to pc_q+4 > IMEM_LIMIT, including 32-bit wrap from 32'hFFFF_FFFC to 0, SHALL deliver the last legal instruction normally, then enter FAULT with fault_cause=10 and fault_addr equal to the incremented value.
REQ-018 In FAULT, fault_valid SHALL be 1 and no new instruction SHALL be captured; FAULT SHALL be sticky until a redirect to a legal aligned address, which returns to FETCH with fault_valid=0 on the next edge.
REQ-019 Addition SHALL be 32-bit modulo arithmetic, and range checks SHALL use 33-bit compares so that wrap is detected.

Reset
REQ-020 While rst_n=0, the block SHALL asynchronously set pc_q=RESET_PC, state=FETCH, out_valid=0, out_pc/out_instr/out_pc_plus4=0, fault_valid=0, fault_cause=00 and fault_addr=0.
REQ-021 The first out_valid=1 SHALL appear after the first rising edge following rst_n deassertion, with out_pc=RESET_PC.
REQ-022 Reset asserted mid-stall or in FAULT SHALL discard the held instruction and fault state.

Structure
REQ-023 Package fetch_pkg SHALL hold the fault_cause enum, the state enum, and the RESET_PC/IMEM_BASE/IMEM_LIMIT default constants.
REQ-024 The address check (alignment plus range) SHALL be one combinational sub-module, fetch_addr_check, instanced for both the redirect path and the sequential path.

Verification
REQ-025 Reset release, out_ready=1, memory at words 0x8000_0000..0x8000_000C = 0x00000013, 0x00100093, 0x00200113, 0x00300193 -> out_pc 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C on consecutive cycles with matching out_instr.
REQ-026 out_ready=0 for 3 cycles while out_pc=0x8000_0004 -> outputs and imem_addr=0x8000_0008 stable; on release the next out_pc is 0x8000_0008.
REQ-027 redirect_pc=0x8000_0100 with out_valid=1 and out_ready=0 -> next cycle out_valid=0; the cycle after, out_pc=0x8000_0100.
REQ-028 redirect_pc=0x8000_0102 -> fault_valid=1, fault_cause=01, fault_addr=0x8000_0102, with no further out_valid; then redirect_pc=0x8000_0000 -> fault cleared and fetch resumes.
REQ-029 Sequential fetch reaching 0x8000_FFFC -> that instruction is delivered, then fault_cause=10 and fault_addr=0x8001_0000.
REQ-030 rst_n pulsed low mid-stall -> out_valid=0 immediately, then restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default address map for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_IMEM_BASE  = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_IMEM_LIMIT = 32'h8000_FFFF;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'b00,
    FAULT_MISALIGNED = 2'b01,
    FAULT_RANGE      = 2'b10
  } fault_cause_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // Misalignment wins over range when both apply.
  function automatic fault_cause_e classify_addr(input logic misaligned,
                                                 input logic out_of_range);
    if (misaligned) begin
      return FAULT_MISALIGNED;
    end
    if (out_of_range) begin
      return FAULT_RANGE;
    end
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Alignment and range check of a fetch address; the extra top bit carries
// any wrap out of 32 bits so a wrapped increment reads as out of range.
module fetch_addr_check
  import fetch_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
  parameter logic [31:0] IMEM_LIMIT = DEFAULT_IMEM_LIMIT
) (
  input  logic [32:0] addr,
  output logic [1:0]  cause
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (addr < {1'b0, IMEM_BASE}) || (addr > {1'b0, IMEM_LIMIT});
    cause        = classify_addr(misaligned, out_of_range);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-issue instruction fetch stage: one-cycle fetch from a combinational
// memory into a valid/ready output register, with redirect and sticky fault.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
  parameter logic [31:0] IMEM_LIMIT = DEFAULT_IMEM_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_plus4;
  logic [32:0]  seq_addr_ext;
  logic [1:0]   seq_cause;
  logic [1:0]   redir_cause;
  logic         fetch_en;

  assign imem_addr    = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign seq_addr_ext = {1'b0, pc_q} + 33'd4;

  // A new word is captured only when the output slot is empty or draining.
  assign fetch_en = (state_q == ST_FETCH) && (!out_valid || out_ready);

  fetch_addr_check #(
    .IMEM_BASE (IMEM_BASE),
    .IMEM_LIMIT(IMEM_LIMIT)
  ) u_redir_check (
    .addr ({1'b0, redirect_pc}),
    .cause(redir_cause)
  );

  fetch_addr_check #(
    .IMEM_BASE (IMEM_BASE),
    .IMEM_LIMIT(IMEM_LIMIT)
  ) u_seq_check (
    .addr (seq_addr_ext),
    .cause(seq_cause)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      out_valid    <= 1'b0;
      out_pc       <= 32'd0;
      out_instr    <= 32'd0;
      out_pc_plus4 <= 32'd0;
      fault_valid  <= 1'b0;
      fault_cause  <= FAULT_NONE;
      fault_addr   <= 32'd0;
    end else if (redirect_valid) begin
      // Flush; anything handed over this cycle has already been consumed.
      out_valid <= 1'b0;
      pc_q      <= redirect_pc;
      if (redir_cause != FAULT_NONE) begin
        state_q     <= ST_FAULT;
        fault_valid <= 1'b1;
        fault_cause <= redir_cause;
        fault_addr  <= redirect_pc;
      end else begin
        state_q     <= ST_FETCH;
        fault_valid <= 1'b0;
        fault_cause <= FAULT_NONE;
        fault_addr  <= 32'd0;
      end
    end else if (fetch_en) begin
      out_valid    <= 1'b1;
      out_pc       <= pc_q;
      out_instr    <= imem_rdata;
      out_pc_plus4 <= pc_plus4;
      pc_q         <= pc_plus4;
      // The current word is legal and still delivered; only its successor faults.
      if (seq_cause != FAULT_NONE) begin
        state_q     <= ST_FAULT;
        fault_valid <= 1'b1;
        fault_cause <= seq_cause;
        fault_addr  <= pc_plus4;
      end
    end else if (state_q == ST_FAULT && out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a default-map instance fed by a word
// array, plus a top-of-address-space instance that exercises 32-bit wrap.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_pc_plus4;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc_plus4;
  logic        w_fault_valid;
  logic [1:0]  w_fault_cause;
  logic [31:0] w_fault_addr;

  logic [31:0] mem [0:16383];
  logic [31:0] mem_off;
  logic        mem_hit;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_pc_plus4  (out_pc_plus4),
    .fault_valid   (fault_valid),
    .fault_cause   (fault_cause),
    .fault_addr    (fault_addr)
  );

  instr_fetch_unit #(
    .RESET_PC  (32'hFFFF_FFF8),
    .IMEM_BASE (32'hFFFF_FFF0),
    .IMEM_LIMIT(32'hFFFF_FFFF)
  ) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (w_imem_addr),
    .imem_rdata    (w_imem_rdata),
    .redirect_valid(w_redirect_valid),
    .redirect_pc   (w_redirect_pc),
    .out_valid     (w_out_valid),
    .out_ready     (w_out_ready),
    .out_pc        (w_out_pc),
    .out_instr     (w_out_instr),
    .out_pc_plus4  (w_out_pc_plus4),
    .fault_valid   (w_fault_valid),
    .fault_cause   (w_fault_cause),
    .fault_addr    (w_fault_addr)
  );

  assign mem_off      = imem_addr - 32'h8000_0000;
  assign mem_hit      = (imem_addr[31:16] == 16'h8000);
  assign imem_rdata   = mem_hit ? mem[mem_off[15:2]] : 32'hDEAD_BEEF;
  assign w_imem_rdata = w_imem_addr ^ 32'h5A5A_5A5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_0193;

    rst_n            = 1'b0;
    out_ready        = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'd0;
    w_out_ready      = 1'b1;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'd0;

    repeat (3) tick();
    check_eq("rst out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst imem_addr", imem_addr, 32'h8000_0000);
    check_eq("rst out_pc", out_pc, 32'd0);
    check_eq("rst fault_valid", {31'd0, fault_valid}, 32'd0);

    // Straight-line fetch; wrap instance walks off the top of the address space.
    rst_n = 1'b1;
    tick();
    check_eq("seq0 valid", {31'd0, out_valid}, 32'd1);
    check_eq("seq0 pc", out_pc, 32'h8000_0000);
    check_eq("seq0 instr", out_instr, 32'h0000_0013);
    check_eq("seq0 pc+4", out_pc_plus4, 32'h8000_0004);
    check_eq("wrap0 pc", w_out_pc, 32'hFFFF_FFF8);
    check_eq("wrap0 instr", w_out_instr, 32'hA5A5_A5A2);
    check_eq("wrap0 fault", {31'd0, w_fault_valid}, 32'd0);
    tick();
    check_eq("seq1 pc", out_pc, 32'h8000_0004);
    check_eq("seq1 instr", out_instr, 32'h0010_0093);
    check_eq("wrap1 pc", w_out_pc, 32'hFFFF_FFFC);
    check_eq("wrap1 valid", {31'd0, w_out_valid}, 32'd1);
    check_eq("wrap1 fault", {31'd0, w_fault_valid}, 32'd1);
    check_eq("wrap1 cause", {30'd0, w_fault_cause}, 32'd2);
    check_eq("wrap1 faddr", w_fault_addr, 32'd0);
    tick();
    check_eq("seq2 pc", out_pc, 32'h8000_0008);
    check_eq("seq2 instr", out_instr, 32'h0020_0113);
    check_eq("wrap2 valid", {31'd0, w_out_valid}, 32'd0);
    tick();
    check_eq("seq3 pc", out_pc, 32'h8000_000C);
    check_eq("seq3 instr", out_instr, 32'h0030_0193);
    check_eq("seq3 imem_addr", imem_addr, 32'h8000_0010);

    // Stall with 0x8000_0004 held at the output.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    tick();
    check_eq("rd0 flush", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    check_eq("rd0 pc", out_pc, 32'h8000_0000);
    tick();
    check_eq("pre-stall pc", out_pc, 32'h8000_0004);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall pc", out_pc, 32'h8000_0004);
      check_eq("stall instr", out_instr, 32'h0010_0093);
      check_eq("stall imem_addr", imem_addr, 32'h8000_0008);
    end
    out_ready = 1'b1;
    tick();
    check_eq("unstall pc", out_pc, 32'h8000_0008);
    check_eq("unstall instr", out_instr, 32'h0020_0113);

    // Redirect while the output is stalled.
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    check_eq("rd1 flush", {31'd0, out_valid}, 32'd0);
    check_eq("rd1 imem_addr", imem_addr, 32'h8000_0100);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick();
    check_eq("rd1 valid", {31'd0, out_valid}, 32'd1);
    check_eq("rd1 pc", out_pc, 32'h8000_0100);
    check_eq("rd1 instr", out_instr, 32'hC0DE_0040);

    // Faulting redirects, then recovery.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    check_eq("mis fault", {31'd0, fault_valid}, 32'd1);
    check_eq("mis cause", {30'd0, fault_cause}, 32'd1);
    check_eq("mis faddr", fault_addr, 32'h8000_0102);
    check_eq("mis valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    repeat (2) begin
      tick();
      check_eq("sticky valid", {31'd0, out_valid}, 32'd0);
      check_eq("sticky fault", {31'd0, fault_valid}, 32'd1);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h7FFF_FFFC;
    tick();
    check_eq("low cause", {30'd0, fault_cause}, 32'd2);
    check_eq("low faddr", fault_addr, 32'h7FFF_FFFC);
    redirect_pc = 32'h0000_0001;
    tick();
    check_eq("both cause", {30'd0, fault_cause}, 32'd1);
    redirect_pc = 32'h8000_0000;
    tick();
    check_eq("clr fault", {31'd0, fault_valid}, 32'd0);
    check_eq("clr cause", {30'd0, fault_cause}, 32'd0);
    check_eq("clr valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    check_eq("resume valid", {31'd0, out_valid}, 32'd1);
    check_eq("resume pc", out_pc, 32'h8000_0000);

    // Run into the top of instruction memory.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick();
    check_eq("end0 pc", out_pc, 32'h8000_FFF8);
    check_eq("end0 instr", out_instr, 32'hC0DE_3FFE);
    check_eq("end0 fault", {31'd0, fault_valid}, 32'd0);
    tick();
    check_eq("end1 pc", out_pc, 32'h8000_FFFC);
    check_eq("end1 instr", out_instr, 32'hC0DE_3FFF);
    check_eq("end1 valid", {31'd0, out_valid}, 32'd1);
    check_eq("end1 fault", {31'd0, fault_valid}, 32'd1);
    check_eq("end1 cause", {30'd0, fault_cause}, 32'd2);
    check_eq("end1 faddr", fault_addr, 32'h8001_0000);
    tick();
    check_eq("end2 valid", {31'd0, out_valid}, 32'd0);
    tick();
    check_eq("end3 valid", {31'd0, out_valid}, 32'd0);
    check_eq("end3 fault", {31'd0, fault_valid}, 32'd1);

    // Reset pulsed during a stall.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
    tick();
    redirect_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    tick();
    check_eq("hold pc", out_pc, 32'h8000_0000);
    check_eq("hold imem_addr", imem_addr, 32'h8000_0004);
    rst_n = 1'b0;
    #1;
    check_eq("arst valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst pc", out_pc, 32'd0);
    check_eq("arst imem_addr", imem_addr, 32'h8000_0000);
    check_eq("arst wrap fault", {31'd0, w_fault_valid}, 32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    check_eq("restart valid", {31'd0, out_valid}, 32'd1);
    check_eq("restart pc", out_pc, 32'h8000_0000);
    check_eq("restart instr", out_instr, 32'h0000_0013);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
